// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller: prescaler, period counter, per-channel duty
// registers with period-aligned LEVEL update. Define LED_PWM_FADE_EN for hardware fade.
module led_pwm_ctrl #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 8,
    parameter int PRE_W = 16
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [31:0]     wr_data,
    input  logic [3:0]      rd_addr,
    output logic [31:0]     rd_data,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_done
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             en_q, en_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q [N_CH];
    logic [WIDTH-1:0] duty_d [N_CH];
    logic [WIDTH-1:0] level_q [N_CH];
    logic [WIDTH-1:0] level_d [N_CH];
    logic [N_CH-1:0]  pwm_q, pwm_d;
    logic             period_done_q, period_done_d;
    logic             running, tick, wrap;
    logic             unused_wr_data;
`ifdef LED_PWM_FADE_EN
    logic [N_CH-1:0]  fade_q, fade_d;
`endif

    assign unused_wr_data = ^wr_data;

    always_comb begin
        en_d       = en_q;
        prescale_d = prescale_q;
        for (int i = 0; i < N_CH; i++) begin
            duty_d[i] = duty_q[i];
        end
`ifdef LED_PWM_FADE_EN
        fade_d = fade_q;
`endif
        if (wr_en) begin
            if (wr_addr == 4'd0) begin
                en_d = wr_data[0];
`ifdef LED_PWM_FADE_EN
                fade_d = wr_data[N_CH:1];
`endif
            end else if (wr_addr == 4'd1) begin
                prescale_d = wr_data[PRE_W-1:0];
            end
            for (int i = 0; i < N_CH; i++) begin
                if (int'(wr_addr) == 2 + i) begin
                    duty_d[i] = wr_data[WIDTH-1:0];
                end
            end
        end
    end

    // Counters only run while EN is set both now and after this edge, so a
    // disable or enable always leaves pre_cnt/cnt at 0.
    always_comb begin
        running = en_q & en_d;
        tick    = running && (pre_cnt_q == prescale_q);
        wrap    = tick && (cnt_q == CNT_MAX);

        if (!running || tick || (wr_en && wr_addr == 4'd1)) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        if (!running) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        period_done_d = wrap;
    end

    // LEVEL only changes at a wrap (or continuously while disabled) and always
    // from the pre-write DUTY, so a write on the wrap tick waits a period.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            level_d[i] = level_q[i];
`ifdef LED_PWM_FADE_EN
            if (!en_q) begin
                if (!fade_q[i]) begin
                    level_d[i] = duty_q[i];
                end
            end else if (wrap) begin
                if (!fade_q[i]) begin
                    level_d[i] = duty_q[i];
                end else if (level_q[i] < duty_q[i]) begin
                    level_d[i] = level_q[i] + 1'b1;
                end else if (level_q[i] > duty_q[i]) begin
                    level_d[i] = level_q[i] - 1'b1;
                end
            end
`else
            if (!en_q || wrap) begin
                level_d[i] = duty_q[i];
            end
`endif
            pwm_d[i] = en_d & (cnt_d < level_d[i]);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q          <= 1'b0;
            prescale_q    <= '0;
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            pwm_q         <= '0;
            period_done_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i]  <= '0;
                level_q[i] <= '0;
            end
        end else begin
            en_q          <= en_d;
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            period_done_q <= period_done_d;
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i]  <= duty_d[i];
                level_q[i] <= level_d[i];
            end
        end
    end

`ifdef LED_PWM_FADE_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fade_q <= '0;
        end else begin
            fade_q <= fade_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (rd_addr == 4'd0) begin
            rd_data[0] = en_q;
`ifdef LED_PWM_FADE_EN
            rd_data[N_CH:1] = fade_q;
`endif
        end else if (rd_addr == 4'd1) begin
            rd_data[PRE_W-1:0] = prescale_q;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (int'(rd_addr) == 2 + i) begin
                rd_data[WIDTH-1:0] = duty_q[i];
            end
            if (int'(rd_addr) == 2 + N_CH + i) begin
                rd_data[WIDTH-1:0] = level_q[i];
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign period_done = period_done_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl (N_CH=3, WIDTH=4): register table,
// directed period/fade/enable/reset sequences and random traffic vs a model.
module tb_led_pwm_ctrl;
    localparam int N_CH   = 3;
    localparam int WIDTH  = 4;
    localparam int PRE_W  = 16;
    localparam int PERIOD = 16;
`ifdef LED_PWM_FADE_EN
    localparam bit FADE_IMPL = 1'b1;
`else
    localparam bit FADE_IMPL = 1'b0;
`endif

    logic            HCLK    = 1'b0;
    logic            HRESETn = 1'b0;
    logic            wr_en   = 1'b0;
    logic [3:0]      wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic [3:0]      rd_addr = '0;
    logic [31:0]     rd_data;
    logic [N_CH-1:0] pwm_out;
    logic            period_done;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: plain integers following the register-level rules
    int mEn, mFade, mPrescale, mPre, mCnt, mPd;
    int mDuty  [N_CH];
    int mLevel [N_CH];
    int mPwm   [N_CH];

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [15];

    led_pwm_ctrl #(.N_CH(N_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .pwm_out(pwm_out),
        .period_done(period_done)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mEn = 0; mFade = 0; mPrescale = 0; mPre = 0; mCnt = 0; mPd = 0;
        for (int i = 0; i < N_CH; i++) begin
            mDuty[i] = 0; mLevel[i] = 0; mPwm[i] = 0;
        end
    endtask

    function automatic logic [31:0] modelRead(input int addr);
        if (addr == 0) return 32'(mEn + 2 * mFade);
        if (addr == 1) return 32'(mPrescale);
        if (addr >= 2 && addr < 2 + N_CH) return 32'(mDuty[addr - 2]);
        if (addr >= 2 + N_CH && addr < 2 + 2 * N_CH) return 32'(mLevel[addr - 2 - N_CH]);
        return 32'd0;
    endfunction

    // One clock edge of the model, using the write currently on the port
    task automatic modelStep();
        int nEn, nFade, nPrescale, nPre, nCnt, idx;
        int nDuty [N_CH];
        int nLevel [N_CH];
        bit running, tick, wrap, fadeOn;
        nEn = mEn; nFade = mFade; nPrescale = mPrescale;
        for (int i = 0; i < N_CH; i++) nDuty[i] = mDuty[i];
        idx = int'(wr_addr);
        if (wr_en) begin
            if (idx == 0) begin
                nEn   = int'(wr_data[0]);
                nFade = FADE_IMPL ? int'(wr_data[3:1]) : 0;
            end else if (idx == 1) begin
                nPrescale = int'(wr_data[15:0]);
            end else if (idx < 2 + N_CH) begin
                nDuty[idx - 2] = int'(wr_data[3:0]);
            end
        end
        running = (mEn != 0) && (nEn != 0);
        tick    = running && (mPre == mPrescale);
        wrap    = tick && (mCnt == PERIOD - 1);
        nPre    = (!running || tick || (wr_en && idx == 1)) ? 0 : mPre + 1;
        nCnt    = !running ? 0 : (tick ? (mCnt + 1) % PERIOD : mCnt);
        for (int i = 0; i < N_CH; i++) begin
            fadeOn    = ((mFade >> i) & 1) != 0;
            nLevel[i] = mLevel[i];
            if (mEn == 0) begin
                if (!fadeOn) nLevel[i] = mDuty[i];
            end else if (wrap) begin
                if (!fadeOn) nLevel[i] = mDuty[i];
                else if (mLevel[i] < mDuty[i]) nLevel[i] = mLevel[i] + 1;
                else if (mLevel[i] > mDuty[i]) nLevel[i] = mLevel[i] - 1;
            end
        end
        mEn = nEn; mFade = nFade; mPrescale = nPrescale; mPre = nPre; mCnt = nCnt;
        mPd = wrap ? 1 : 0;
        for (int i = 0; i < N_CH; i++) begin
            mDuty[i]  = nDuty[i];
            mLevel[i] = nLevel[i];
            mPwm[i]   = (nEn != 0 && nCnt < nLevel[i]) ? 1 : 0;
        end
    endtask

    task automatic checkOutput();
        logic [N_CH-1:0] expPwm;
        for (int i = 0; i < N_CH; i++) expPwm[i] = (mPwm[i] != 0);
        checkValue("model pwm_out", 32'(pwm_out), 32'(expPwm));
        checkValue("model period_done", 32'(period_done), 32'(mPd));
        checkValue("model rd_data", rd_data, modelRead(int'(rd_addr)));
    endtask

    // Drive one cycle from a negedge; outputs are compared at the next negedge
    task automatic applyStimulus(input logic we, input logic [3:0] addr,
                                 input logic [31:0] data, input logic [3:0] rd);
        wr_en = we; wr_addr = addr; wr_data = data; rd_addr = rd;
        @(posedge HCLK);
        modelStep();
        @(negedge HCLK);
        wr_en = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n, input logic [3:0] rd);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'd0, 32'd0, rd);
    endtask

    task automatic waitPd(input logic [3:0] rd);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 4'd0, 32'd0, rd);
            n++;
        end while (!period_done && n < 300);
        checkValue("period_done within bound", 32'(period_done), 32'd1);
    endtask

    task automatic doReset();
        wr_en = 1'b0;
        HRESETn = 1'b0;
        modelReset();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        int hi0, hi1, hiOther, pdCnt, pwmAt3;
        int fadeExp [6];
        logic [31:0] d;
        logic [3:0] a;

        // Register reset/readback table, run with EN=0
        vecs[0]  = '{1'b0, 4'd0,  32'h0,     4'd0,  32'h0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,     4'd1,  32'h0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,     4'd2,  32'h0};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,     4'd5,  32'h0};
        vecs[4]  = '{1'b1, 4'd1,  32'h12345, 4'd1,  32'h2345};
        vecs[5]  = '{1'b1, 4'd2,  32'hFFA,   4'd2,  32'hA};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,     4'd5,  32'hA};
        vecs[7]  = '{1'b1, 4'd5,  32'h3,     4'd5,  32'hA};
        vecs[8]  = '{1'b1, 4'd14, 32'hFFFF,  4'd14, 32'h0};
        vecs[9]  = '{1'b1, 4'd3,  32'h7,     4'd3,  32'h7};
        vecs[10] = '{1'b1, 4'd0,  32'h1E,    4'd0,  FADE_IMPL ? 32'hE : 32'h0};
        vecs[11] = '{1'b0, 4'd0,  32'h0,     4'd8,  32'h0};
        vecs[12] = '{1'b1, 4'd4,  32'h9,     4'd4,  32'h9};
        vecs[13] = '{1'b1, 4'd0,  32'h0,     4'd0,  32'h0};
        vecs[14] = '{1'b0, 4'd0,  32'h0,     4'd7,  32'h9};

        doReset();
        checkValue("reset pwm_out", 32'(pwm_out), 32'd0);
        checkValue("reset period_done", 32'(period_done), 32'd0);
        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].rd);
            checkValue($sformatf("table vec%0d rd_data", v), rd_data, vecs[v].exp);
        end

        // Basic period: DUTY0=4, PRESCALE=0 -> 4 high of 16, pulse every 16
        doReset();
        applyStimulus(1'b1, 4'd2, 32'd4, 4'd0);
        applyStimulus(1'b1, 4'd0, 32'd1, 4'd0);
        hi0 = int'(pwm_out[0]); hiOther = int'(|pwm_out[2:1]); pdCnt = int'(period_done);
        for (int j = 1; j < 48; j++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
            hi0 += int'(pwm_out[0]); hiOther += int'(|pwm_out[2:1]); pdCnt += int'(period_done);
        end
        checkValue("duty4 high cycles in 3 periods", 32'(hi0), 32'd12);
        checkValue("duty4 period_done pulses", 32'(pdCnt), 32'd2);
        checkValue("idle channels stay low", 32'(hiOther), 32'd0);

        // DUTY0=15 written on the wrap tick: old duty 4 used for one more period
        applyStimulus(1'b1, 4'd2, 32'd15, 4'd5);
        checkValue("wrap-tick write period_done", 32'(period_done), 32'd1);
        hi0 = int'(pwm_out[0]);
        for (int j = 1; j < 16; j++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd5);
            hi0 += int'(pwm_out[0]);
        end
        checkValue("write on wrap keeps old duty", 32'(hi0), 32'd4);
        hi0 = 0;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd5);
            hi0 += int'(pwm_out[0]);
        end
        checkValue("duty15 high cycles", 32'(hi0), 32'd15);
        applyStimulus(1'b1, 4'd2, 32'd0, 4'd5);
        hi0 = int'(pwm_out[0]);
        for (int j = 1; j < 16; j++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd5);
            hi0 += int'(pwm_out[0]);
        end
        checkValue("duty0 write on wrap keeps 15", 32'(hi0), 32'd15);
        hi0 = 0;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd5);
            hi0 += int'(pwm_out[0]);
        end
        checkValue("duty0 constant low", 32'(hi0), 32'd0);

        // PRESCALE=2, DUTY1=8 -> 48-cycle period; mid-period DUTY1=2 waits a period
        applyStimulus(1'b1, 4'd1, 32'd2, 4'd6);
        applyStimulus(1'b1, 4'd3, 32'd8, 4'd6);
        waitPd(4'd6);
        waitPd(4'd6);
        hi0 = int'(pwm_out[1]); hi1 = 0; pdCnt = 0;
        for (int j = 1; j < 96; j++) begin
            if (j == 10) applyStimulus(1'b1, 4'd3, 32'd2, 4'd6);
            else applyStimulus(1'b0, 4'd0, 32'd0, 4'd6);
            if (j < 48) hi0 += int'(pwm_out[1]);
            else hi1 += int'(pwm_out[1]);
            pdCnt += int'(period_done);
            if (j == 48) checkValue("prescale2 pulse at 48", 32'(period_done), 32'd1);
        end
        checkValue("prescale2 duty8 high cycles", 32'(hi0), 32'd24);
        checkValue("prescale2 duty2 next period", 32'(hi1), 32'd6);
        checkValue("prescale2 pulses in 96 cycles", 32'(pdCnt), 32'd1);

        // Fade: LEVEL0 walks 0->3 one step per period, then back down to 1
        if (FADE_IMPL) fadeExp = '{1, 2, 3, 3, 2, 1};
        else           fadeExp = '{3, 3, 3, 3, 1, 1};
        doReset();
        applyStimulus(1'b1, 4'd0, 32'd2, 4'd5);
        applyStimulus(1'b1, 4'd2, 32'd3, 4'd5);
        applyStimulus(1'b1, 4'd0, 32'd3, 4'd5);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) applyStimulus(1'b1, 4'd2, 32'd1, 4'd5);
            waitPd(4'd5);
            checkValue($sformatf("fade LEVEL0 step%0d", k), rd_data, 32'(fadeExp[k]));
        end

        // EN falling drops the output next cycle; re-enable restarts at cnt=0
        doReset();
        applyStimulus(1'b1, 4'd2, 32'd15, 4'd0);
        applyStimulus(1'b1, 4'd0, 32'd1, 4'd0);
        idle(3, 4'd0);
        checkValue("enabled pwm high", 32'(pwm_out[0]), 32'd1);
        applyStimulus(1'b1, 4'd0, 32'd0, 4'd0);
        checkValue("disable pwm_out", 32'(pwm_out), 32'd0);
        applyStimulus(1'b1, 4'd2, 32'd1, 4'd0);
        applyStimulus(1'b1, 4'd1, 32'd2, 4'd0);
        applyStimulus(1'b1, 4'd0, 32'd1, 4'd0);
        hi0 = int'(pwm_out[0]); pwmAt3 = 0;
        for (int j = 1; j < 6; j++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
            hi0 += int'(pwm_out[0]);
            if (j == 3) pwmAt3 = int'(pwm_out[0]);
        end
        checkValue("re-enable cnt0 lasts prescale+1", 32'(hi0), 32'd3);
        checkValue("re-enable first tick low", 32'(pwmAt3), 32'd0);

        // Asynchronous reset in the middle of a high phase
        doReset();
        applyStimulus(1'b1, 4'd2, 32'd15, 4'd2);
        applyStimulus(1'b1, 4'd0, 32'd1, 4'd2);
        idle(5, 4'd2);
        checkValue("pre-reset pwm high", 32'(pwm_out[0]), 32'd1);
        #2 HRESETn = 1'b0;
        modelReset();
        #1;
        checkValue("async reset pwm_out", 32'(pwm_out), 32'd0);
        checkValue("async reset period_done", 32'(period_done), 32'd0);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 4'(r);
            #1;
            checkValue($sformatf("async reset reg%0d", r), rd_data, 32'd0);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        idle(20, 4'd0);

        // Random register traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 4'($urandom_range(0, 15));
                d = $urandom;
                if ($urandom_range(0, 1) == 0) a = 4'($urandom_range(0, 4));
                if (a == 4'd0) d[0] = ($urandom_range(0, 5) != 0);
                if (a == 4'd1) d = 32'($urandom_range(0, 3));
                applyStimulus(1'b1, a, d, 4'($urandom_range(0, 15)));
            end else begin
                applyStimulus(1'b0, 4'd0, 32'd0, 4'($urandom_range(0, 15)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
